// File: rtl/axi_sram_bridge_burst.sv
// AXI slave to dual-port SRAM bridge with FIXED/INCR bursts, one read and one write burst in flight.
// Read data returns through a credit-checked buffer so m_rready backpressure never loses beats.
module axi_sram_bridge_burst #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int IW         = 4,
  parameter int RAM_LAT    = 1,
  parameter int RBUF_DEPTH = 4
) (
  input  logic            aclk,
  input  logic            areset,
  output logic [AW-1:0]   ram_raddr,
  output logic            ram_ren,
  input  logic [DW-1:0]   ram_rdata,
  output logic [AW-1:0]   ram_waddr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wen,
  input  logic [AW-1:0]   m_araddr,
  input  logic [7:0]      m_arlen,
  input  logic [2:0]      m_arsize,
  input  logic [1:0]      m_arburst,
  input  logic [IW-1:0]   m_arid,
  input  logic            m_arvalid,
  output logic            m_arready,
  output logic [DW-1:0]   m_rdata,
  output logic [IW-1:0]   m_rid,
  output logic [1:0]      m_rresp,
  output logic            m_rlast,
  output logic            m_rvalid,
  input  logic            m_rready,
  input  logic [AW-1:0]   m_awaddr,
  input  logic [7:0]      m_awlen,
  input  logic [2:0]      m_awsize,
  input  logic [1:0]      m_awburst,
  input  logic [IW-1:0]   m_awid,
  input  logic            m_awvalid,
  output logic            m_awready,
  input  logic [DW-1:0]   m_wdata,
  input  logic [DW/8-1:0] m_wstrb,
  input  logic            m_wlast,
  input  logic            m_wvalid,
  output logic            m_wready,
  output logic [IW-1:0]   m_bid,
  output logic [1:0]      m_bresp,
  output logic            m_bvalid,
  input  logic            m_bready,
  output logic [1:0]      dbg_r_state,
  output logic [1:0]      dbg_w_state
);
  // Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
  // a source holds its payload stable while valid=1 and ready=0.
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DW/8));
  localparam int CW = $clog2(RBUF_DEPTH + 1);
  localparam int PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                              input logic [1:0] bt);
    return (bt == 2'b00) ? a : a + (AW'(1) << sz);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- read engine ----------------
  r_state_t              r_state, r_next;
  logic [AW-1:0]         r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [IW-1:0]         r_id;
  logic                  r_err, r_issue, r_pop, r_push;
  logic [CW-1:0]         r_outst, buf_cnt;
  logic [RAM_LAT-1:0]    pipe_v, pipe_last;
  logic [DW-1:0]         buf_data [RBUF_DEPTH];
  logic [RBUF_DEPTH-1:0] buf_last;
  logic [PW-1:0]         wr_ptr, rd_ptr;

  assign m_rvalid  = (buf_cnt != '0);
  assign m_rdata   = buf_data[rd_ptr];
  assign m_rlast   = buf_last[rd_ptr];
  assign m_rid     = r_id;
  assign m_rresp   = r_err ? 2'b10 : 2'b00;
  assign ram_raddr = r_addr;
  assign r_pop     = m_rvalid && m_rready;
  assign r_push    = pipe_v[RAM_LAT-1];
  assign dbg_r_state = r_state;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    m_arready = 1'b0;
    ram_ren   = 1'b0;
    r_issue   = 1'b0;
    case (r_state)
      R_IDLE: begin
        m_arready = 1'b1;
        if (m_arvalid) r_next = R_ISSUE;
      end
      R_ISSUE: begin
        // Credits cover both in-flight reads and buffered beats, so the buffer cannot overflow.
        if (r_outst < CW'(RBUF_DEPTH)) begin
          r_issue = 1'b1;
          ram_ren = !r_err;
          if (r_cnt == r_len) r_next = R_DRAIN;
        end
      end
      R_DRAIN: if (r_pop && m_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_outst   <= '0;
      buf_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      if (m_arready && m_arvalid) begin
        r_addr  <= m_araddr;
        r_len   <= m_arlen;
        r_size  <= m_arsize;
        r_burst <= m_arburst;
        r_id    <= m_arid;
        r_err   <= (m_arsize > MAX_SIZE);
        r_cnt   <= '0;
      end else if (r_issue) begin
        r_addr <= step_addr(r_addr, r_size, r_burst);
        r_cnt  <= r_cnt + 8'd1;
      end
      pipe_v[0]    <= r_issue;
      pipe_last[0] <= (r_cnt == r_len);
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      if (r_push) wr_ptr <= ptr_inc(wr_ptr);
      if (r_pop)  rd_ptr <= ptr_inc(rd_ptr);
      buf_cnt <= buf_cnt + CW'(r_push) - CW'(r_pop);
      r_outst <= r_outst + CW'(r_issue) - CW'(r_pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (r_push) begin
      buf_data[wr_ptr] <= r_err ? '0 : ram_rdata;
      buf_last[wr_ptr] <= pipe_last[RAM_LAT-1];
    end
  end

  // ---------------- write engine ----------------
  w_state_t      w_state, w_next;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_len, w_cnt;
  logic [2:0]    w_size;
  logic [1:0]    w_burst;
  logic [IW-1:0] w_id;
  logic          w_err, w_size_err, w_beat_last;

  assign w_beat_last = (w_cnt == w_len);
  assign ram_waddr   = w_addr;
  assign ram_wdata   = m_wdata;
  assign m_bid       = w_id;
  assign m_bresp     = (w_err || w_size_err) ? 2'b10 : 2'b00;
  assign dbg_w_state = w_state;

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next    = w_state;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    ram_wen   = '0;
    case (w_state)
      W_IDLE: begin
        m_awready = 1'b1;
        if (m_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        m_wready = 1'b1;
        if (m_wvalid) begin
          ram_wen = w_size_err ? '0 : m_wstrb;
          if (m_wlast || w_beat_last) w_next = W_RESP;
        end
      end
      W_RESP: begin
        m_bvalid = 1'b1;
        if (m_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_cnt      <= '0;
      w_err      <= 1'b0;
      w_size_err <= 1'b0;
    end else if (m_awready && m_awvalid) begin
      w_addr     <= m_awaddr;
      w_len      <= m_awlen;
      w_size     <= m_awsize;
      w_burst    <= m_awburst;
      w_id       <= m_awid;
      w_cnt      <= '0;
      w_err      <= 1'b0;
      w_size_err <= (m_awsize > MAX_SIZE);
    end else if (m_wready && m_wvalid) begin
      w_addr <= step_addr(w_addr, w_size, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      // Early wlast and missing wlast on the final beat are both protocol errors.
      if (m_wlast != w_beat_last) w_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_sram_bridge_burst.sv
// Directed bench for axi_sram_bridge_burst: SRAM model with RAM_LAT read latency,
// expected queues for SRAM reads, R beats and SRAM writes, checked every falling edge.
module tb_axi_sram_bridge_burst;
  localparam int AW = 32, DW = 32, IW = 4, RAM_LAT = 2, RBUF_DEPTH = 4;

  logic aclk = 1'b0;
  logic areset;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic ram_ren;
  logic [DW-1:0] ram_rdata, ram_wdata;
  logic [3:0] ram_wen;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_awburst, m_rresp, m_bresp, dbg_r_state, dbg_w_state;
  logic [IW-1:0] m_arid, m_awid, m_rid, m_bid;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [3:0] m_wstrb;

  always #5 aclk = ~aclk;

  axi_sram_bridge_burst #(.AW(AW), .DW(DW), .IW(IW), .RAM_LAT(RAM_LAT), .RBUF_DEPTH(RBUF_DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awid(m_awid), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // SRAM model: data for the address presented RAM_LAT cycles earlier
  logic [AW-1:0] sa1, sa2;
  always @(posedge aclk) begin
    sa1 <= ram_raddr;
    sa2 <= sa1;
  end
  assign ram_rdata = mem_f(sa2);

  logic [31:0] exp_ra_q[$];
  logic [38:0] exp_r_q[$];
  logic [67:0] exp_w_q[$];

  int checks = 0, failures = 0, cyc = 0;
  int ren_cnt = 0, first_ren = -1, last_ren = -1, issued = 0, popped = 0;
  bit saw_rlast = 0, stall_prev = 0, track_os = 0;
  logic [31:0] held_data;
  logic held_last;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [38:0] e;
    logic [67:0] w;
    cyc++;
    if (areset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("r_hold_valid", 72'(m_rvalid), 72'd1);
        check("r_hold_data", 72'({m_rlast, m_rdata}), 72'({held_last, held_data}));
      end
      if (ram_ren) begin
        ren_cnt++;
        issued++;
        if (first_ren < 0) first_ren = cyc;
        last_ren = cyc;
        if (exp_ra_q.size() == 0) check("ren_unexpected", 72'd1, 72'd0);
        else check("ram_raddr", 72'(ram_raddr), 72'(exp_ra_q.pop_front()));
      end
      if (m_rvalid && m_rready) begin
        popped++;
        if (exp_r_q.size() == 0) check("r_unexpected", 72'd1, 72'd0);
        else begin
          e = exp_r_q.pop_front();
          check("r_beat", 72'({m_rid, m_rresp, m_rlast, m_rdata}), 72'(e));
          if (m_rlast) saw_rlast = 1;
        end
      end
      if (track_os) check("outstanding_le_4", 72'((issued - popped) <= 4), 72'd1);
      if (ram_wen != 4'h0) begin
        if (exp_w_q.size() == 0) check("wen_unexpected", 72'd1, 72'd0);
        else begin
          w = exp_w_q.pop_front();
          check("ram_write", 72'({ram_waddr, ram_wdata, ram_wen}), 72'(w));
        end
      end
      stall_prev = m_rvalid && !m_rready;
      held_data  = m_rdata;
      held_last  = m_rlast;
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    logic [31:0] a;
    bit err, hs;
    err = (size > 3'd2);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (!err) exp_ra_q.push_back(a);
      exp_r_q.push_back({id, err ? 2'b10 : 2'b00, (i == int'(len)), err ? 32'd0 : mem_f(a)});
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
    m_araddr = addr; m_arlen = len; m_arsize = size; m_arburst = burst; m_arid = id;
    m_arvalid = 1'b1;
    hs = 0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk);
      hs = m_arready;
      monitor();
      @(posedge aclk);
      #1;
    end
    m_arvalid = 1'b0;
    if (!hs) check("ar_timeout", 72'd0, 72'd1);
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    bit hs;
    m_awaddr = addr; m_awlen = len; m_awsize = size; m_awburst = burst; m_awid = id;
    m_awvalid = 1'b1;
    hs = 0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk);
      hs = m_awready;
      monitor();
      @(posedge aclk);
      #1;
    end
    m_awvalid = 1'b0;
    if (!hs) check("aw_timeout", 72'd0, 72'd1);
  endtask

  task automatic send_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    bit hs;
    exp_w_q.push_back({addr, data, strb});
    m_wdata = data; m_wstrb = strb; m_wlast = last; m_wvalid = 1'b1;
    hs = 0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk);
      hs = m_wready;
      monitor();
      @(posedge aclk);
      #1;
    end
    m_wvalid = 1'b0;
    m_wlast = 1'b0;
    if (!hs) check("w_timeout", 72'd0, 72'd1);
  endtask

  task automatic wait_rlast(input int budget);
    saw_rlast = 0;
    for (int i = 0; i < budget && !saw_rlast; i++) cycle();
    if (!saw_rlast) check("rlast_timeout", 72'd0, 72'd1);
  endtask

  task automatic wait_b(input int budget);
    for (int i = 0; i < budget && !m_bvalid; i++) cycle();
    check("bvalid_seen", 72'(m_bvalid), 72'd1);
  endtask

  initial begin
    areset = 1'b1;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arid = '0; m_arvalid = 1'b0;
    m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awid = '0; m_awvalid = 1'b0;
    m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
    m_rready = 1'b0; m_bready = 1'b0;
    repeat (3) cycle();
    areset = 1'b0;
    @(negedge aclk);
    check("rst_outputs", 72'({m_arready, m_awready, m_rvalid, m_bvalid, m_wready, ram_ren, ram_wen}),
          72'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}));
    @(posedge aclk);
    #1;

    // 1: 4-beat INCR read, no backpressure
    m_rready = 1'b1;
    send_ar(32'h100, 8'd3, 3'd2, 2'b01, 4'h3);
    cycle();
    check("arready_busy", 72'(m_arready), 72'd0);
    wait_rlast(40);
    check("ren_count", 72'(ren_cnt), 72'd4);
    check("ren_consecutive", 72'(last_ren - first_ren), 72'd3);
    check("arready_idle", 72'(m_arready), 72'd1);

    // 2: 8-beat read stalled by rready=0 for 10 cycles
    m_rready = 1'b0;
    issued = 0; popped = 0; track_os = 1;
    send_ar(32'h100, 8'd7, 3'd2, 2'b01, 4'hA);
    repeat (10) cycle();
    check("stall_issue_cap", 72'(issued), 72'd4);
    m_rready = 1'b1;
    wait_rlast(60);
    track_os = 0;
    check("r_queue_drained", 72'(exp_r_q.size()), 72'd0);

    // 3: 2-beat FIXED write to 0x40
    send_aw(32'h40, 8'd1, 3'd2, 2'b00, 4'h5);
    send_w(32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
    send_w(32'h40, 32'h12345678, 4'h3, 1'b1);
    wait_b(20);
    check("bresp_ok", 72'({m_bid, m_bresp}), 72'({4'h5, 2'b00}));
    repeat (3) cycle();
    check("bvalid_held", 72'(m_bvalid), 72'd1);
    m_bready = 1'b1;
    cycle();
    m_bready = 1'b0;
    check("b_done", 72'({m_bvalid, m_awready}), 72'({1'b0, 1'b1}));

    // 4: len=3 write with early wlast on beat 2
    send_aw(32'h80, 8'd3, 3'd2, 2'b01, 4'h6);
    send_w(32'h80, 32'hA0A0A0A0, 4'hF, 1'b0);
    send_w(32'h84, 32'hB1B1B1B1, 4'hF, 1'b1);
    wait_b(20);
    check("bresp_early_wlast", 72'({m_bid, m_bresp}), 72'({4'h6, 2'b10}));
    m_bready = 1'b1;
    cycle();
    m_bready = 1'b0;
    check("w_idle_after_err", 72'({dbg_w_state, m_awready}), 72'({2'd0, 1'b1}));
    check("w_queue_drained", 72'(exp_w_q.size()), 72'd0);

    // 5: oversized arsize -> SLVERR beats, no SRAM reads
    ren_cnt = 0;
    send_ar(32'h0, 8'd2, 3'd3, 2'b01, 4'h9);
    wait_rlast(40);
    check("err_no_ren", 72'(ren_cnt), 72'd0);

    // 6: reset during beat 2 of an 8-beat read
    popped = 0;
    send_ar(32'h200, 8'd7, 3'd2, 2'b01, 4'h1);
    for (int i = 0; i < 40 && popped < 1; i++) cycle();
    check("beat1_popped", 72'(popped >= 1), 72'd1);
    areset = 1'b1;
    exp_r_q.delete();
    exp_ra_q.delete();
    cycle();
    areset = 1'b0;
    check("post_rst", 72'({m_rvalid, m_arready}), 72'({1'b0, 1'b1}));
    repeat (5) cycle();
    send_ar(32'h300, 8'd1, 3'd2, 2'b01, 4'h2);
    wait_rlast(40);
    check("post_rst_drained", 72'(exp_r_q.size() + exp_ra_q.size()), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
